mcs4_rom_responder: RTL

Bus-side responder for one 4001-style program ROM on the MCS-4 4-bit multiplexed bus; the counterpart of the CPU's instruction-fetch initiator. It tracks the 8-phase instruction cycle from SYNC and captures the 12-bit address during A1–A3. When selected, it drives the addressed byte as OPR/OPA in M1/M2. It also implements the ROM I/O port (SRC chip select, WRR/RDR) and a host-side program-load port for the PYNQ processing system.

---
 rtl/mcs4_rom_responder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mcs4_rom_responder.sv
// 4001-style program ROM responder on the MCS-4 multiplexed bus.
// It tracks the bus phase from SYNC, serves opcode fetches, and handles the SRC/WRR/RDR I/O port.
module mcs4_rom_responder #(
  parameter logic [3:0] Rom_id      = 4'd0,
  parameter logic [3:0] Io_out_mask = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sync,
  input  logic       cm_rom,
  input  logic [3:0] d_in,
  output logic [3:0] d_out,
  output logic       d_oe,
  input  logic [3:0] io_in,
  output logic [3:0] io_out,
  input  logic       prog_we,
  input  logic [7:0] prog_addr,
  input  logic [7:0] prog_data
);

  localparam logic [3:0] OPA_WRR = 4'b0010;
  localparam logic [3:0] OPA_RDR = 4'b1010;

  typedef enum logic [2:0] {
    PH_A1 = 3'd0, PH_A2 = 3'd1, PH_A3 = 3'd2, PH_M1 = 3'd3,
    PH_M2 = 3'd4, PH_X1 = 3'd5, PH_X2 = 3'd6, PH_X3 = 3'd7
  } phase_t;

  logic [7:0] r_mem [256];

  phase_t     r_phase,   w_phase_nxt;
  logic       r_locked,  w_locked_nxt;
  logic [7:0] r_addr,    w_addr_nxt;
  logic [7:0] r_fetch,   w_fetch_nxt;
  logic       r_rom_sel, w_rom_sel_nxt;
  logic       r_src_sel, w_src_sel_nxt;
  logic       r_io_cyc,  w_io_cyc_nxt;
  logic [3:0] r_opa,     w_opa_nxt;
  logic [3:0] r_io_out,  w_io_out_nxt;
  logic       r_d_oe,    w_d_oe_nxt;
  logic [3:0] r_d_out,   w_d_out_nxt;

  logic [7:0] w_rd_byte;
  logic       w_hit;

  assign w_rd_byte = r_mem[r_addr];
  assign w_hit     = cm_rom & (d_in == Rom_id);

  // Array has no reset; the host may load it at any time, even while the bus runs.
  always_ff @(posedge clk) begin
    if (prog_we) r_mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase   <= PH_A1;
      r_locked  <= 1'b0;
      r_addr    <= 8'h00;
      r_fetch   <= 8'h00;
      r_rom_sel <= 1'b0;
      r_src_sel <= 1'b0;
      r_io_cyc  <= 1'b0;
      r_opa     <= 4'h0;
      r_io_out  <= 4'h0;
      r_d_oe    <= 1'b0;
      r_d_out   <= 4'h0;
    end else begin
      r_phase   <= w_phase_nxt;
      r_locked  <= w_locked_nxt;
      r_addr    <= w_addr_nxt;
      r_fetch   <= w_fetch_nxt;
      r_rom_sel <= w_rom_sel_nxt;
      r_src_sel <= w_src_sel_nxt;
      r_io_cyc  <= w_io_cyc_nxt;
      r_opa     <= w_opa_nxt;
      r_io_out  <= w_io_out_nxt;
      r_d_oe    <= w_d_oe_nxt;
      r_d_out   <= w_d_out_nxt;
    end
  end

  // Outputs are registered one phase early: the case arm for phase P prepares the drive for P+1.
  always_comb begin
    w_phase_nxt   = r_phase;
    w_locked_nxt  = r_locked;
    w_addr_nxt    = r_addr;
    w_fetch_nxt   = r_fetch;
    w_rom_sel_nxt = r_rom_sel;
    w_src_sel_nxt = r_src_sel;
    w_io_cyc_nxt  = r_io_cyc;
    w_opa_nxt     = r_opa;
    w_io_out_nxt  = r_io_out;
    w_d_oe_nxt    = 1'b0;
    w_d_out_nxt   = 4'h0;

    if (sync) begin
      w_phase_nxt   = PH_A1;
      w_locked_nxt  = 1'b1;
      w_rom_sel_nxt = 1'b0;
      w_io_cyc_nxt  = 1'b0;
    end else if (r_locked) begin
      w_phase_nxt = phase_t'(r_phase + 3'd1);
      case (r_phase)
        PH_A1: w_addr_nxt[3:0] = d_in;
        PH_A2: w_addr_nxt[7:4] = d_in;
        PH_A3: begin
          w_rom_sel_nxt = w_hit;
          w_fetch_nxt   = w_rd_byte;
          if (w_hit) begin
            w_d_oe_nxt  = 1'b1;
            w_d_out_nxt = w_rd_byte[7:4];
          end
        end
        PH_M1: begin
          if (r_rom_sel) begin
            w_d_oe_nxt  = 1'b1;
            w_d_out_nxt = r_fetch[3:0];
          end
        end
        PH_M2: begin
          w_opa_nxt    = d_in;
          w_io_cyc_nxt = cm_rom & r_src_sel;
        end
        PH_X1: begin
          if (r_io_cyc && (r_opa == OPA_RDR)) begin
            w_d_oe_nxt  = 1'b1;
            w_d_out_nxt = (io_in & ~Io_out_mask) | (r_io_out & Io_out_mask);
          end
        end
        PH_X2: begin
          // Inside an I/O instruction the X2 nibble is data, never an SRC chip number.
          if (r_io_cyc) begin
            if (r_opa == OPA_WRR) w_io_out_nxt = d_in & Io_out_mask;
          end else if (cm_rom) begin
            w_src_sel_nxt = (d_in == Rom_id);
          end
        end
        default: ;
      endcase
    end
  end

  assign d_oe   = r_d_oe;
  assign d_out  = r_d_out;
  assign io_out = r_io_out;

endmodule
